// File: rtl/spu_issue_scoreboard.sv
// Purpose: per-register pending-result scoreboard; holds the ID instruction on RAW/WAW hazards.
// Latency: issue_ready/issue_fire/stall/pending_count are combinational; counters update on clk.
// Backpressure: stall holds ID in place (nop into ST3); nothing is recorded for unfired instructions.
// Ports: clk/reset_n; ID request (id_valid, id_ra/rb/rc + *_used, id_rt, id_rt_write, id_latency);
//        flush, clear_stats; outputs issue_ready, issue_fire, stall, pending_count, stall_count.
module spu_issue_scoreboard #(
    parameter int NUM_REGS = 128,
    parameter int REG_W    = 7,
    parameter int LAT_W    = 3,
    parameter int STAT_W   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_ra,
    input  logic [REG_W-1:0]  id_rb,
    input  logic [REG_W-1:0]  id_rc,
    input  logic              id_ra_used,
    input  logic              id_rb_used,
    input  logic              id_rc_used,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              id_rt_write,
    input  logic [LAT_W-1:0]  id_latency,
    input  logic              flush,
    input  logic              clear_stats,
    output logic              issue_ready,
    output logic              issue_fire,
    output logic              stall,
    output logic [7:0]        pending_count,
    output logic [STAT_W-1:0] stall_count
);

    // Cycles remaining until each register's in-flight result is forwardable.
    logic [LAT_W-1:0] pend [NUM_REGS];

    logic raw_hazard;
    logic waw_hazard;

    assign raw_hazard = (id_ra_used && (pend[id_ra] != '0)) ||
                        (id_rb_used && (pend[id_rb] != '0)) ||
                        (id_rc_used && (pend[id_rc] != '0));

    // A new write may not become visible before an older write to the same target.
    assign waw_hazard = id_rt_write && (pend[id_rt] > id_latency);

    assign issue_ready = ~flush & ~raw_hazard & ~waw_hazard;
    assign issue_fire  = id_valid & issue_ready;
    assign stall       = id_valid & ~issue_ready;

    always_comb begin
        pending_count = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (pend[r] != '0) begin
                pending_count = pending_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pend[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (flush) begin
                    pend[r] <= '0;
                end else if (issue_fire && id_rt_write && (id_rt == REG_W'(r))) begin
                    // New producer overrides the running decrement; latency 0 clears.
                    pend[r] <= id_latency;
                end else if (pend[r] != '0) begin
                    pend[r] <= pend[r] - LAT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if (clear_stats) begin
            stall_count <= '0;
        end else if (stall && !(&stall_count)) begin
            stall_count <= stall_count + STAT_W'(1);
        end
    end

endmodule

// File: tb/tb_spu_issue_scoreboard.sv
module tb_spu_issue_scoreboard;

    logic        clk;
    logic        reset_n;
    logic        id_valid;
    logic [6:0]  id_ra, id_rb, id_rc;
    logic        id_ra_used, id_rb_used, id_rc_used;
    logic [6:0]  id_rt;
    logic        id_rt_write;
    logic [2:0]  id_latency;
    logic        flush;
    logic        clear_stats;
    logic        issue_ready;
    logic        issue_fire;
    logic        stall;
    logic [7:0]  pending_count;
    logic [15:0] stall_count;

    int n_cmp = 0;
    int n_err = 0;

    spu_issue_scoreboard dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .id_valid      (id_valid),
        .id_ra         (id_ra),
        .id_rb         (id_rb),
        .id_rc         (id_rc),
        .id_ra_used    (id_ra_used),
        .id_rb_used    (id_rb_used),
        .id_rc_used    (id_rc_used),
        .id_rt         (id_rt),
        .id_rt_write   (id_rt_write),
        .id_latency    (id_latency),
        .flush         (flush),
        .clear_stats   (clear_stats),
        .issue_ready   (issue_ready),
        .issue_fire    (issue_fire),
        .stall         (stall),
        .pending_count (pending_count),
        .stall_count   (stall_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: each register remembers the absolute cycle at which its
    // result becomes forwardable; the remaining wait is derived from the cycle count.
    int unsigned ready_at [128];
    int unsigned cyc      = 0;
    int unsigned m_stalls = 0;

    function automatic int unsigned m_pend(input int r);
        return (ready_at[r] > cyc) ? (ready_at[r] - cyc) : 0;
    endfunction

    function automatic bit m_ready();
        if (flush) return 1'b0;
        if (id_ra_used && m_pend(int'(id_ra)) != 0) return 1'b0;
        if (id_rb_used && m_pend(int'(id_rb)) != 0) return 1'b0;
        if (id_rc_used && m_pend(int'(id_rc)) != 0) return 1'b0;
        if (id_rt_write && m_pend(int'(id_rt)) > int'(id_latency)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int r = 0; r < 128; r++) if (m_pend(r) != 0) c++;
        return c;
    endfunction

    task automatic m_clear();
        for (int r = 0; r < 128; r++) ready_at[r] = 0;
    endtask

    // Advance one clock edge, updating the model with the inputs seen at that edge.
    task automatic tick();
        bit fire_now, stall_now;
        fire_now  = id_valid && m_ready();
        stall_now = id_valid && !m_ready();
        @(posedge clk);
        cyc++;
        if (flush) m_clear();
        else if (fire_now && id_rt_write) ready_at[id_rt] = cyc + int'(id_latency);
        if (clear_stats) m_stalls = 0;
        else if (stall_now && m_stalls < 65535) m_stalls++;
        #1;
    endtask

    task automatic set_instr(input logic v,
                             input logic [6:0] ra, input logic ua,
                             input logic [6:0] rb, input logic ub,
                             input logic [6:0] rc, input logic uc,
                             input logic [6:0] rt, input logic w, input logic [2:0] lat);
        id_valid = v;
        id_ra = ra; id_ra_used = ua;
        id_rb = rb; id_rb_used = ub;
        id_rc = rc; id_rc_used = uc;
        id_rt = rt; id_rt_write = w; id_latency = lat;
    endtask

    task automatic idle(input int n);
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; flush = 0; clear_stats = 0;
        set_instr(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (pending_count !== 8'd0) begin n_err++; $display("FAIL reset_pcount: got %0d want 0", pending_count); end
        n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", issue_ready); end
        n_cmp++; if (issue_fire !== 1'b1) begin n_err++; $display("FAIL reset_fire: got %b want 1", issue_fire); end
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_cmp++; if (stall_count !== 16'd0) begin n_err++; $display("FAIL reset_scount: got %0d want 0", stall_count); end
        reset_n = 1'b1;
        idle(1);
    endtask

    task automatic test_raw_latency();
        set_instr(1, 0, 0, 0, 0, 0, 0, 7'd5, 1, 3'd3);
        #1;
        n_cmp++; if (issue_fire !== 1'b1) begin n_err++; $display("FAIL raw_producer_fire: got %b want 1", issue_fire); end
        tick();
        set_instr(1, 7'd5, 1, 0, 0, 0, 0, 7'd6, 0, 3'd0);
        for (int k = 1; k <= 3; k++) begin
            #1;
            n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL raw_stall k=%0d: got %b want 1", k, stall); end
            n_cmp++; if (pending_count !== 8'd1) begin n_err++; $display("FAIL raw_pcount k=%0d: got %0d want 1", k, pending_count); end
            tick();
        end
        #1;
        n_cmp++; if (issue_fire !== 1'b1) begin n_err++; $display("FAIL raw_fire: got %b want 1", issue_fire); end
        n_cmp++; if (pending_count !== 8'd0) begin n_err++; $display("FAIL raw_pcount_end: got %0d want 0", pending_count); end
        tick();
        idle(1);
    endtask

    task automatic test_forward_and_waw();
        set_instr(1, 0, 0, 0, 0, 0, 0, 7'd9, 1, 3'd0);
        tick();
        set_instr(1, 7'd9, 1, 0, 0, 0, 0, 0, 0, 3'd0);
        #1;
        n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL fwd_ready: got %b want 1", issue_ready); end
        n_cmp++; if (pending_count !== 8'd0) begin n_err++; $display("FAIL fwd_pcount: got %0d want 0", pending_count); end
        tick();
        // WAW: a shorter-latency write behind a longer one must wait.
        set_instr(1, 0, 0, 0, 0, 0, 0, 7'd9, 1, 3'd2);
        tick();
        set_instr(1, 0, 0, 0, 0, 0, 0, 7'd9, 1, 3'd0);
        for (int k = 1; k <= 2; k++) begin
            #1;
            n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL waw_stall k=%0d: got %b want 1", k, stall); end
            tick();
        end
        #1;
        n_cmp++; if (issue_fire !== 1'b1) begin n_err++; $display("FAIL waw_fire: got %b want 1", issue_fire); end
        tick();
        set_instr(1, 0, 0, 0, 0, 0, 0, 7'd9, 1, 3'd2);
        tick();
        set_instr(1, 0, 0, 0, 0, 0, 0, 7'd9, 1, 3'd5);
        #1;
        n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL waw_long_ready: got %b want 1", issue_ready); end
        tick();
        set_instr(1, 0, 0, 0, 0, 0, 0, 0, 1, 3'd4);
        #1;
        n_cmp++; if (pending_count !== 8'd1) begin n_err++; $display("FAIL waw_long_pcount: got %0d want 1", pending_count); end
        // Write-with-latency-4 to r9 is blocked (pend 5 > 4); latency 5 passes.
        id_rt = 7'd9;
        #1;
        n_cmp++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL waw_long_block: got %b want 0", issue_ready); end
        idle(8);
    endtask

    task automatic test_unused_and_multi();
        set_instr(1, 0, 0, 0, 0, 0, 0, 7'd7, 1, 3'd3);
        tick();
        set_instr(1, 7'd7, 0, 7'd7, 0, 7'd7, 0, 0, 0, 3'd0);
        #1;
        n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL unused_ready: got %b want 1", issue_ready); end
        id_rb_used = 1'b1;
        #1;
        n_cmp++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL used_rb_ready: got %b want 0", issue_ready); end
        idle(4);
        set_instr(1, 0, 0, 0, 0, 0, 0, 7'd11, 1, 3'd5);
        tick();
        set_instr(1, 0, 0, 0, 0, 0, 0, 7'd10, 1, 3'd2);
        tick();
        set_instr(1, 7'd10, 1, 0, 0, 7'd11, 1, 0, 0, 3'd0);
        for (int k = 1; k <= 4; k++) begin
            #1;
            n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL multi_stall k=%0d: got %b want 1", k, stall); end
            tick();
        end
        #1;
        n_cmp++; if (issue_fire !== 1'b1) begin n_err++; $display("FAIL multi_fire: got %b want 1", issue_fire); end
        idle(2);
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) begin
            set_instr(1, 0, 0, 0, 0, 0, 0, 7'(20 + k), 1, 3'd7);
            tick();
        end
        set_instr(1, 7'd40, 1, 0, 0, 0, 0, 0, 0, 3'd0);
        flush = 1'b1;
        #1;
        n_cmp++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready: got %b want 0", issue_ready); end
        n_cmp++; if (pending_count !== 8'd3) begin n_err++; $display("FAIL flush_pcount_before: got %0d want 3", pending_count); end
        tick();
        flush = 1'b0;
        set_instr(1, 7'd20, 1, 7'd21, 1, 7'd22, 1, 0, 0, 3'd0);
        #1;
        n_cmp++; if (pending_count !== 8'd0) begin n_err++; $display("FAIL flush_pcount_after: got %0d want 0", pending_count); end
        n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready_after: got %b want 1", issue_ready); end
        idle(1);
    endtask

    task automatic test_async_reset();
        set_instr(1, 0, 0, 0, 0, 0, 0, 7'd30, 1, 3'd6);
        tick();
        idle(2);
        n_cmp++; if (pending_count !== 8'd1) begin n_err++; $display("FAIL areset_pcount_before: got %0d want 1", pending_count); end
        reset_n = 1'b0;
        #1;
        m_clear();
        m_stalls = 0;
        n_cmp++; if (pending_count !== 8'd0) begin n_err++; $display("FAIL areset_pcount: got %0d want 0", pending_count); end
        n_cmp++; if (stall_count !== 16'd0) begin n_err++; $display("FAIL areset_scount: got %0d want 0", stall_count); end
        #1;
        reset_n = 1'b1;
        idle(1);
    endtask

    task automatic test_random();
        bit held = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!held) begin
                set_instr($urandom_range(0, 3) != 0,
                          7'($urandom_range(0, 7)), $urandom_range(0, 1) != 0,
                          7'($urandom_range(0, 7)), $urandom_range(0, 1) != 0,
                          7'($urandom_range(0, 7)), $urandom_range(0, 1) != 0,
                          7'($urandom_range(0, 7)), $urandom_range(0, 2) != 0,
                          3'($urandom_range(0, 7)));
            end
            flush       = ($urandom_range(0, 31) == 0);
            clear_stats = ($urandom_range(0, 63) == 0);
            #1;
            n_cmp++; if (issue_ready !== m_ready()) begin n_err++; $display("FAIL rnd_ready i=%0d: got %b want %b", i, issue_ready, m_ready()); end
            n_cmp++; if (issue_fire !== (id_valid && m_ready())) begin n_err++; $display("FAIL rnd_fire i=%0d: got %b", i, issue_fire); end
            n_cmp++; if (stall !== (id_valid && !m_ready())) begin n_err++; $display("FAIL rnd_stall i=%0d: got %b", i, stall); end
            n_cmp++; if (int'(pending_count) != m_count()) begin n_err++; $display("FAIL rnd_pcount i=%0d: got %0d want %0d", i, pending_count, m_count()); end
            n_cmp++; if (int'(stall_count) != int'(m_stalls)) begin n_err++; $display("FAIL rnd_scount i=%0d: got %0d want %0d", i, stall_count, m_stalls); end
            held = id_valid && !m_ready() && !flush;
            tick();
        end
        flush = 1'b0; clear_stats = 1'b0;
        idle(8);
    endtask

    task automatic test_stall_saturation();
        set_instr(1, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0);
        flush = 1'b1; clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        repeat (65540) tick();
        #1;
        n_cmp++; if (stall_count !== 16'hFFFF) begin n_err++; $display("FAIL sat_scount: got %h want ffff", stall_count); end
        n_cmp++; if (int'(stall_count) != int'(m_stalls)) begin n_err++; $display("FAIL sat_model: got %0d want %0d", stall_count, m_stalls); end
        clear_stats = 1'b1;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL clr_stall: got %b want 1", stall); end
        tick();
        clear_stats = 1'b0;
        #1;
        n_cmp++; if (stall_count !== 16'd0) begin n_err++; $display("FAIL clr_scount: got %0d want 0", stall_count); end
        flush = 1'b0;
        idle(1);
    endtask

    initial begin
        m_clear();
        test_reset();
        test_raw_latency();
        test_forward_and_waw();
        test_unused_and_multi();
        test_flush();
        test_async_reset();
        test_random();
        test_stall_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
